// File: rtl/ltssm_substate_sequencer_pkg.sv
// ltssm_pkg: shared LTSSM definitions.
//   - Substate encodings driven on the substate bus to the Tx/Rx LTSSM halves.
//   - Sequencer FSM state type.
//   - Gen limits and a helper that checks a requested Gen is in range.
package ltssm_pkg;

    localparam logic [4:0] DETECT_QUIET      = 5'd0;
    localparam logic [4:0] DETECT_ACTIVE     = 5'd1;
    localparam logic [4:0] POLLING_ACTIVE    = 5'd2;
    localparam logic [4:0] POLLING_CONFIG    = 5'd3;
    localparam logic [4:0] CONFIG_LW_START   = 5'd4;
    localparam logic [4:0] CONFIG_LW_ACCEPT  = 5'd5;
    localparam logic [4:0] CONFIG_LN_WAIT    = 5'd6;
    localparam logic [4:0] CONFIG_LN_ACCEPT  = 5'd7;
    localparam logic [4:0] CONFIG_COMPLETE   = 5'd8;
    localparam logic [4:0] CONFIG_IDLE       = 5'd9;
    localparam logic [4:0] L0                = 5'd10;
    localparam logic [4:0] RECOVERY_RCVRLOCK = 5'd11;
    localparam logic [4:0] RECOVERY_RCVRCFG  = 5'd12;
    localparam logic [4:0] RECOVERY_SPEED    = 5'd13;
    localparam logic [4:0] RECOVERY_IDLE     = 5'd14;

    localparam logic [2:0] GEN_MIN = 3'd1;
    localparam logic [2:0] GEN_MAX = 3'd5;

    typedef enum logic [1:0] {
        S_LAUNCH = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } seq_state_e;

    function automatic logic gen_valid(input logic [2:0] g);
        return (g >= GEN_MIN) && (g <= GEN_MAX);
    endfunction

endpackage

// File: rtl/ltssm_substate_sequencer_if.sv
// ltssm_substate_sequencer_if: handshake bundle between the sequencer and the
// Tx/Rx LTSSM halves.
//   txFinish/txExitTo : Tx half done with the current substate + requested next
//   rxFinish/rxExitTo : Rx half done with the current substate + requested next
//   substate          : shared current substate
//   startTx/startRx   : launch pulses for the current substate
// master = sequencer side, slave = LTSSM half side.
interface ltssm_substate_sequencer_if;
    logic       txFinish;
    logic [4:0] txExitTo;
    logic       rxFinish;
    logic [4:0] rxExitTo;
    logic [4:0] substate;
    logic       startTx;
    logic       startRx;

    modport master (
        input  txFinish, txExitTo, rxFinish, rxExitTo,
        output substate, startTx, startRx
    );

    modport slave (
        output txFinish, txExitTo, rxFinish, rxExitTo,
        input  substate, startTx, startRx
    );
endinterface

// File: rtl/ltssm_substate_sequencer_watchdog.sv
// ltssm_watchdog: per-substate timeout counter.
//   clk, reset (async, active-low)
//   clr : synchronous clear to zero (has priority over en)
//   en  : count one per cycle; holds at WATCHDOG_MAX
//   tc  : count has reached WATCHDOG_MAX
module ltssm_watchdog #(
    parameter int                    WATCHDOG_W   = 20,
    parameter logic [WATCHDOG_W-1:0] WATCHDOG_MAX = {WATCHDOG_W{1'b1}}
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WATCHDOG_W-1:0] count_q;
    logic [WATCHDOG_W-1:0] count_d;

    assign tc = (count_q == WATCHDOG_MAX);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ltssm_substate_sequencer.sv
// ltssm_substate_sequencer: owns the shared LTSSM substate register.
// Launches the Tx/Rx halves for each substate, collects their finish/exitTo
// handshakes, commits the next substate, and tracks the operating Gen and
// the directed speed-change request.
// Ports:
//   clk, reset (async, active-low)
//   lif                   : handshake bundle (master side), see interface
//   enable                : 0 parks the sequencer in DETECT_QUIET
//   speedChangeReq        : level request to retrain to targetGen
//   targetGen             : requested Gen 1..5
//   Gen, trainToGen       : current / training Gen
//   directed_speed_change : set on accepted request until RECOVERY_SPEED is left
//   linkUp                : substate == L0
//   watchdogErr           : one-cycle pulse on watchdog expiry
module ltssm_substate_sequencer
    import ltssm_pkg::*;
#(
    parameter int                    DEVICETYPE   = 0,
    parameter int                    WATCHDOG_W   = 20,
    parameter logic [WATCHDOG_W-1:0] WATCHDOG_MAX = 20'hFFFFF
) (
    input  logic                              clk,
    input  logic                              reset,
    ltssm_substate_sequencer_if.master        lif,
    input  logic                              enable,
    input  logic                              speedChangeReq,
    input  logic [2:0]                        targetGen,
    output logic [2:0]                        Gen,
    output logic [2:0]                        trainToGen,
    output logic                              directed_speed_change,
    output logic                              linkUp,
    output logic                              watchdogErr
);

    seq_state_e state_q, state_d;
    logic [4:0] substate_q, substate_d;
    logic       start_q, start_d;
    logic       tx_done_q, tx_done_d;
    logic       rx_done_q, rx_done_d;
    logic [4:0] tx_exit_q, tx_exit_d;
    logic [4:0] rx_exit_q, rx_exit_d;
    logic [2:0] gen_q, gen_d;
    logic [2:0] ttg_q, ttg_d;
    logic       dsc_q, dsc_d;
    logic       force_q, force_d;     // pending forced exit to RECOVERY_RCVRLOCK
    logic       wd_err_q, wd_err_d;

    logic       wd_clr;
    logic       wd_en;
    logic       wd_tc;
    logic       speed_accept;
    logic [4:0] commit_target;

    ltssm_watchdog #(
        .WATCHDOG_W   (WATCHDOG_W),
        .WATCHDOG_MAX (WATCHDOG_MAX)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .tc    (wd_tc)
    );

    assign lif.substate          = substate_q;
    assign lif.startTx           = start_q;
    assign lif.startRx           = start_q;
    assign Gen                   = gen_q;
    assign trainToGen            = ttg_q;
    assign directed_speed_change = dsc_q;
    assign linkUp                = (substate_q == L0);
    assign watchdogErr           = wd_err_q;

    always_comb begin
        state_d       = state_q;
        substate_d    = substate_q;
        start_d       = 1'b0;
        tx_done_d     = tx_done_q;
        rx_done_d     = rx_done_q;
        tx_exit_d     = tx_exit_q;
        rx_exit_d     = rx_exit_q;
        gen_d         = gen_q;
        ttg_d         = ttg_q;
        dsc_d         = dsc_q;
        force_d       = force_q;
        wd_err_d      = 1'b0;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;
        commit_target = DETECT_QUIET;

        // Not accepted in S_COMMIT so the forced target cannot be lost to a
        // commit that is already leaving L0.
        speed_accept = (DEVICETYPE == 1) && speedChangeReq && (substate_q == L0) &&
                       gen_valid(targetGen) && (targetGen != gen_q) && !dsc_q &&
                       (state_q != S_COMMIT);
        if (speed_accept) begin
            ttg_d   = targetGen;
            dsc_d   = 1'b1;
            force_d = 1'b1;
        end

        case (state_q)
            S_LAUNCH: begin
                tx_done_d = 1'b0;
                rx_done_d = 1'b0;
                wd_clr    = 1'b1;
                if (enable) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                wd_en = 1'b1;
                if (lif.txFinish) begin
                    tx_done_d = 1'b1;
                    tx_exit_d = lif.txExitTo;
                end
                if (lif.rxFinish) begin
                    rx_done_d = 1'b1;
                    rx_exit_d = lif.rxExitTo;
                end
                // Decisions look at the updated latches so a finish pulse
                // moves to S_COMMIT in the cycle after it is seen.
                if ((tx_done_d && rx_done_d) || (rx_done_d && (rx_exit_d == DETECT_QUIET))) begin
                    state_d = S_COMMIT;
                end else if (wd_tc) begin
                    wd_err_d  = 1'b1;
                    rx_exit_d = DETECT_QUIET;
                    state_d   = S_COMMIT;
                end
            end

            S_COMMIT: begin
                // Rx is authoritative; an Rx abort or watchdog (both carried as
                // DETECT_QUIET in rx_exit_q) overrides a pending forced recovery.
                if (rx_exit_q == DETECT_QUIET) begin
                    commit_target = DETECT_QUIET;
                end else if (force_q) begin
                    commit_target = RECOVERY_RCVRLOCK;
                end else begin
                    commit_target = rx_exit_q;
                end
                substate_d = commit_target;
                state_d    = S_LAUNCH;

                if (commit_target == DETECT_QUIET) begin
                    gen_d   = GEN_MIN;
                    ttg_d   = GEN_MIN;
                    dsc_d   = 1'b0;
                    force_d = 1'b0;
                end else begin
                    force_d = 1'b0;
                    if ((substate_q == RECOVERY_SPEED) && (commit_target != RECOVERY_SPEED)) begin
                        gen_d = ttg_q;
                        dsc_d = 1'b0;
                    end
                    // Upstream port has no request of its own: targetGen carries
                    // the rate negotiated by the Rx half when entering RECOVERY_SPEED.
                    if ((DEVICETYPE == 0) && (commit_target == RECOVERY_SPEED) &&
                        gen_valid(targetGen)) begin
                        ttg_d = targetGen;
                    end
                end
            end

            default: begin
                state_d = S_LAUNCH;
            end
        endcase

        // Disable overrides everything: park in DETECT_QUIET with the same
        // side effects as committing DETECT_QUIET, and launch nothing.
        if (!enable) begin
            state_d    = S_LAUNCH;
            substate_d = DETECT_QUIET;
            start_d    = 1'b0;
            wd_clr     = 1'b1;
            wd_err_d   = 1'b0;
            gen_d      = GEN_MIN;
            ttg_d      = GEN_MIN;
            dsc_d      = 1'b0;
            force_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_LAUNCH;
            substate_q <= DETECT_QUIET;
            start_q    <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            tx_exit_q  <= DETECT_QUIET;
            rx_exit_q  <= DETECT_QUIET;
            gen_q      <= GEN_MIN;
            ttg_q      <= GEN_MIN;
            dsc_q      <= 1'b0;
            force_q    <= 1'b0;
            wd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            substate_q <= substate_d;
            start_q    <= start_d;
            tx_done_q  <= tx_done_d;
            rx_done_q  <= rx_done_d;
            tx_exit_q  <= tx_exit_d;
            rx_exit_q  <= rx_exit_d;
            gen_q      <= gen_d;
            ttg_q      <= ttg_d;
            dsc_q      <= dsc_d;
            force_q    <= force_d;
            wd_err_q   <= wd_err_d;
        end
    end

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Testbench for ltssm_substate_sequencer (downstream port, short watchdog).
// Stimulus pushes the expected start / watchdog events into a queue; a monitor
// pops and compares whenever the DUT pulses startTx/startRx or watchdogErr.
module tb_ltssm_substate_sequencer;
    import ltssm_pkg::*;

    localparam int              WD_W   = 8;
    localparam logic [WD_W-1:0] WD_MAX = 8'd30;
    localparam int              WD_N   = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       speedChangeReq = 1'b0;
    logic [2:0] targetGen = 3'd1;
    logic [2:0] Gen;
    logic [2:0] trainToGen;
    logic       directed_speed_change;
    logic       linkUp;
    logic       watchdogErr;

    ltssm_substate_sequencer_if lif ();

    ltssm_substate_sequencer #(
        .DEVICETYPE   (1),
        .WATCHDOG_W   (WD_W),
        .WATCHDOG_MAX (WD_MAX)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .lif                   (lif),
        .enable                (enable),
        .speedChangeReq        (speedChangeReq),
        .targetGen             (targetGen),
        .Gen                   (Gen),
        .trainToGen            (trainToGen),
        .directed_speed_change (directed_speed_change),
        .linkUp                (linkUp),
        .watchdogErr           (watchdogErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int s = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_wd;
        int         cyc;
        logic [4:0] sub;
        logic [2:0] gen;
        logic [2:0] ttg;
        logic       dsc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    // Monitor: one popped expectation per DUT event.
    always @(negedge clk) begin
        exp_t e;
        if (reset && (lif.startTx || lif.startRx || watchdogErr)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: cycle %0d start=%0d wd=%0d, required no event",
                         cyc - base, lif.startTx, watchdogErr);
            end else begin
                e = exp_q.pop_front();
                $display("txn %s cycle=%0d sub=%0d Gen=%0d ttg=%0d dsc=%0d",
                         e.is_wd ? "watchdog" : "start", cyc - base, lif.substate,
                         Gen, trainToGen, directed_speed_change);
                chk("event_cycle", cyc - base, e.cyc);
                chk("watchdogErr", watchdogErr, e.is_wd);
                if (e.is_wd) begin
                    chk("wd_no_start", lif.startTx, 0);
                end else begin
                    chk("startTx", lif.startTx, 1);
                    chk("startRx", lif.startRx, 1);
                    chk("substate", lif.substate, e.sub);
                    chk("Gen", Gen, e.gen);
                    chk("trainToGen", trainToGen, e.ttg);
                    chk("dsc", directed_speed_change, e.dsc);
                    chk("linkUp", linkUp, (e.sub == L0));
                end
            end
        end
    end

    task automatic push_start(input int c, input logic [4:0] sub, input logic [2:0] g,
                              input logic [2:0] t, input logic d);
        exp_t e;
        e.is_wd = 1'b0; e.cyc = c; e.sub = sub; e.gen = g; e.ttg = t; e.dsc = d;
        exp_q.push_back(e);
    endtask

    task automatic push_wd(input int c);
        exp_t e;
        e.is_wd = 1'b1; e.cyc = c; e.sub = '0; e.gen = '0; e.ttg = '0; e.dsc = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc - base < n) @(negedge clk);
        if (cyc - base != n) begin
            n_checks++;
            $display("FAIL schedule: at cycle %0d, required cycle %0d", cyc - base, n);
        end
    endtask

    task automatic fin(input int n, input bit do_rx, input bit do_tx,
                       input logic [4:0] rx_to, input logic [4:0] tx_to);
        wait_cyc(n);
        if (do_rx) begin lif.rxFinish = 1'b1; lif.rxExitTo = rx_to; end
        if (do_tx) begin lif.txFinish = 1'b1; lif.txExitTo = tx_to; end
        @(negedge clk);
        lif.rxFinish = 1'b0;
        lif.txFinish = 1'b0;
    endtask

    // Both halves finish together two cycles after the last start pulse.
    task automatic step(input logic [4:0] to, input logic [2:0] g, input logic [2:0] t, input logic d);
        push_start(s + 5, to, g, t, d);
        fin(s + 2, 1'b1, 1'b1, to, to);
        s = s + 5;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base = cyc;
        s = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        lif.txFinish = 1'b0; lif.rxFinish = 1'b0;
        lif.txExitTo = '0;   lif.rxExitTo = '0;
        enable = 1'b1;

        // 1. reset release: start pulse at cycle 1 in DETECT_QUIET, Gen 1
        push_start(1, DETECT_QUIET, 3'd1, 3'd1, 1'b0);
        release_reset();
        #1;
        chk("rst_substate", lif.substate, 0);
        chk("rst_Gen", Gen, 1);
        chk("rst_trainToGen", trainToGen, 1);
        chk("rst_dsc", directed_speed_change, 0);
        chk("rst_start", lif.startTx, 0);
        chk("rst_linkUp", linkUp, 0);

        // 2. Rx first (exit 1) at 5, Tx at 9 -> substate 1 at 11, start at 12
        push_start(12, DETECT_ACTIVE, 3'd1, 3'd1, 1'b0);
        fin(5, 1'b1, 1'b0, DETECT_ACTIVE, 5'd0);
        fin(9, 1'b0, 1'b1, 5'd0, 5'd7);
        chk("commit_not_early", lif.substate, 0);
        wait_cyc(11);
        chk("commit_latency", lif.substate, 1);

        // 3. Rx abort to DETECT_QUIET, later Tx finishes ignored
        push_start(18, DETECT_QUIET, 3'd1, 3'd1, 1'b0);
        fin(15, 1'b1, 1'b0, DETECT_QUIET, 5'd0);
        fin(16, 1'b0, 1'b1, 5'd0, 5'd9);
        wait_cyc(17);
        chk("abort_substate", lif.substate, 0);
        fin(17, 1'b0, 1'b1, 5'd0, 5'd9);
        push_start(28, POLLING_ACTIVE, 3'd1, 3'd1, 1'b0);
        fin(20, 1'b1, 1'b0, POLLING_ACTIVE, 5'd0);
        fin(25, 1'b0, 1'b1, 5'd0, POLLING_ACTIVE);
        s = 28;

        // 4. watchdog: no finish -> pulse, then DETECT_QUIET
        push_wd(s + 1 + WD_N);
        push_start(s + 3 + WD_N, DETECT_QUIET, 3'd1, 3'd1, 1'b0);
        s = s + 3 + WD_N;

        // 5. reach L0, speed change to Gen 3 (invalid and equal Gen ignored first)
        step(L0, 3'd1, 3'd1, 1'b0);
        wait_cyc(s + 1); speedChangeReq = 1'b1; targetGen = 3'd7;
        wait_cyc(s + 2); targetGen = 3'd1;
        wait_cyc(s + 3);
        chk("spd_ignored_dsc", directed_speed_change, 0);
        chk("spd_ignored_ttg", trainToGen, 1);
        targetGen = 3'd3;
        wait_cyc(s + 4);
        speedChangeReq = 1'b0;
        chk("spd_accept_dsc", directed_speed_change, 1);
        chk("spd_accept_ttg", trainToGen, 3);
        chk("spd_accept_Gen", Gen, 1);
        push_start(s + 8, RECOVERY_RCVRLOCK, 3'd1, 3'd3, 1'b1);
        fin(s + 5, 1'b1, 1'b1, L0, L0);
        s = s + 8;
        step(RECOVERY_SPEED, 3'd1, 3'd3, 1'b1);
        step(RECOVERY_RCVRLOCK, 3'd3, 3'd3, 1'b0);

        // 6. reset in S_WAIT with Rx latched and Tx arriving
        fin(s + 2, 1'b1, 1'b0, RECOVERY_RCVRCFG, 5'd0);
        wait_cyc(s + 3);
        chk("pre_rst_Gen", Gen, 3);
        chk("pre_rst_substate", lif.substate, RECOVERY_RCVRLOCK);
        lif.txFinish = 1'b1; lif.txExitTo = RECOVERY_RCVRCFG;
        reset = 1'b0;
        #1;
        chk("mid_rst_substate", lif.substate, 0);
        chk("mid_rst_Gen", Gen, 1);
        chk("mid_rst_trainToGen", trainToGen, 1);
        chk("mid_rst_dsc", directed_speed_change, 0);
        chk("mid_rst_linkUp", linkUp, 0);
        chk("mid_rst_start", lif.startTx, 0);
        lif.txFinish = 1'b0;
        push_start(1, DETECT_QUIET, 3'd1, 3'd1, 1'b0);
        release_reset();

        // 7. enable low parks in DETECT_QUIET with no start pulses
        step(DETECT_ACTIVE, 3'd1, 3'd1, 1'b0);
        wait_cyc(s + 1); enable = 1'b0;
        wait_cyc(s + 2);
        chk("disable_substate", lif.substate, 0);
        wait_cyc(s + 4);
        push_start(s + 5, DETECT_QUIET, 3'd1, 3'd1, 1'b0);
        enable = 1'b1;

        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                $display("FAIL drain: %0d events pending, required 0", exp_q.size());
            end
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
